// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
//
// Contents:
//   mode_t     - operation select encoding (hold, shift left, shift right, load)
//   cnt_width  - number of bits needed to count 0..w, i.e. $clog2(w+1)
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    // Width of the shift counter for a register of w bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: a WIDTH-bit register with hold, shift-left,
// shift-right and parallel-load modes. It has serial in/out at both ends, so
// instances can be chained (sout_l of one feeds sin_r of the next) to build
// longer shifters. It also counts shifts since the last load and pulses
// word_done once every WIDTH shifts.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   en         in   clock enable; 0 holds all state
//   mode       in   [1:0] 00 hold, 01 shift left, 10 shift right, 11 load
//   d          in   [WIDTH-1:0] parallel load data
//   sin_r      in   serial in at the LSB end (shift left)
//   sin_l      in   serial in at the MSB end (shift right)
//   q          out  [WIDTH-1:0] register contents
//   sout_l     out  q[WIDTH-1]
//   sout_r     out  q[0]
//   shift_cnt  out  [CW-1:0] shifts since last load or wrap
//   word_done  out  one-cycle pulse after every WIDTH-th shift
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter int                 CW        = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    // Counter value on which the next shift completes a full word.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mode_t op;

    assign op     = mode_t'(mode);
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

    // Register, shift counter and word_done pulse. word_done defaults to 0
    // on every edge so that it can only be high for the cycle following the
    // shift that wrapped the counter. Reset takes priority over enable, and
    // enable over mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (en) begin
                case (op)
                    MODE_HOLD: begin
                        q <= q;
                    end
                    MODE_SHL, MODE_SHR: begin
                        if (op == MODE_SHL) begin
                            q <= {q[WIDTH-2:0], sin_r};
                        end else begin
                            q <= {sin_l, q[WIDTH-1:1]};
                        end
                        // Both directions count towards the same word.
                        if (shift_cnt == LAST_CNT) begin
                            shift_cnt <= '0;
                            word_done <= 1'b1;
                        end else begin
                            shift_cnt <= shift_cnt + CW'(1);
                        end
                    end
                    MODE_LOAD: begin
                        q         <= d;
                        shift_cnt <= '0;
                    end
                    default: begin
                        q <= q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): a directed vector table
// covering reset, load/hold, shifting in both directions, enable gating,
// mid-shift reset and load-on-wrap, followed by randomized stimulus compared
// against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  d;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic [CW-1:0] shift_cnt;
    logic          word_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin_r;
        logic       sin_l;
        logic [7:0] exp_q;
        int         exp_cnt;
        logic       exp_wd;
    } vec_t;

    vec_t vecs[$];

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic r, input logic e, input logic [1:0] m,
                           input logic [7:0] dd, input logic sr, input logic sl,
                           input logic [7:0] eq, input int ec, input logic ew);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.d = dd; v.sin_r = sr; v.sin_l = sl;
        v.exp_q = eq; v.exp_cnt = ec; v.exp_wd = ew;
        vecs.push_back(v);
    endtask

    // Drive inputs, then sample one time unit after the next rising edge.
    task automatic apply_stimulus(input logic r, input logic e, input logic [1:0] m,
                                  input logic [7:0] dd, input logic sr, input logic sl);
        reset_n = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, actual, expected);
        end
    endtask

    task automatic check_all(input int idx, input logic [7:0] eq, input int ec, input logic ew);
        check_output("q",         idx, 64'(q),         64'(eq));
        check_output("shift_cnt", idx, 64'(shift_cnt), 64'(ec));
        check_output("word_done", idx, 64'(word_done), 64'(ew));
        check_output("sout_l",    idx, 64'(sout_l),    64'(eq[7]));
        check_output("sout_r",    idx, 64'(sout_r),    64'(eq[0]));
    endtask

    initial begin
        int         mq;
        int         mc;
        logic       mw;
        logic       r, e, sr, sl;
        logic [1:0] m;
        logic [7:0] dd;

        reset_n = 1'b0; en = 1'b0; mode = 2'b00; d = '0; sin_r = 1'b0; sin_l = 1'b0;
        #2;

        // Reset with a load pending: reset must win.
        add_vec(0, 1, 2'b11, 8'hFF, 0, 0, 8'h00, 0, 0);
        add_vec(0, 1, 2'b11, 8'hFF, 0, 0, 8'h00, 0, 0);
        // Load then hold.
        add_vec(1, 1, 2'b11, 8'hA5, 0, 0, 8'hA5, 0, 0);
        add_vec(1, 1, 2'b00, 8'h00, 0, 0, 8'hA5, 0, 0);
        add_vec(1, 1, 2'b00, 8'h00, 0, 0, 8'hA5, 0, 0);
        add_vec(1, 1, 2'b00, 8'h00, 0, 0, 8'hA5, 0, 0);
        // Eight left shifts from A5; pulse after the eighth.
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h4A, 1, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h94, 2, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h28, 3, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h50, 4, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'hA0, 5, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h40, 6, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h80, 7, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 1);
        add_vec(1, 1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 0);
        // Right shifts filling with ones, then a load.
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'h80, 1, 0);
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hC0, 2, 0);
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hE0, 3, 0);
        add_vec(1, 1, 2'b11, 8'h3C, 0, 1, 8'h3C, 0, 0);
        // Five shifts, freeze for four edges, then three more to the wrap.
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h79, 1, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'hF3, 2, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'hE7, 3, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'hCF, 4, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h9F, 5, 0);
        add_vec(1, 0, 2'b01, 8'h00, 1, 0, 8'h9F, 5, 0);
        add_vec(1, 0, 2'b01, 8'h00, 1, 0, 8'h9F, 5, 0);
        add_vec(1, 0, 2'b01, 8'h00, 1, 0, 8'h9F, 5, 0);
        add_vec(1, 0, 2'b01, 8'h00, 1, 0, 8'h9F, 5, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h3E, 6, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'h7C, 7, 0);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'hF8, 0, 1);
        add_vec(1, 1, 2'b01, 8'h00, 0, 0, 8'hF0, 1, 0);
        // Mixed direction up to count 7, then reset on the wrapping edge.
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hF8, 2, 0);
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hFC, 3, 0);
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hFE, 4, 0);
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hFF, 5, 0);
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hFF, 6, 0);
        add_vec(1, 1, 2'b10, 8'h00, 0, 1, 8'hFF, 7, 0);
        add_vec(0, 1, 2'b01, 8'h00, 1, 1, 8'h00, 0, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h01, 1, 0);
        // Load on the edge that would wrap: no pulse.
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h03, 2, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h07, 3, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h0F, 4, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h1F, 5, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h3F, 6, 0);
        add_vec(1, 1, 2'b01, 8'h00, 1, 0, 8'h7F, 7, 0);
        add_vec(1, 1, 2'b11, 8'h55, 1, 0, 8'h55, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].d,
                           vecs[i].sin_r, vecs[i].sin_l);
            check_all(i, vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_wd);
        end

        // Randomized phase: start from a reset, then track the register as
        // an integer 0..255 and the count of shifts since the last load.
        apply_stimulus(0, 1, 2'b00, 8'h00, 0, 0);
        mq = 0; mc = 0; mw = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 39) != 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = 2'($urandom_range(0, 3));
            dd = 8'($urandom);
            sr = 1'($urandom);
            sl = 1'($urandom);
            // Bias towards shifting so that wraps happen often.
            if (m == 2'b11 && $urandom_range(0, 2) != 0) m = 2'b01;
            apply_stimulus(r, e, m, dd, sr, sl);
            mw = 1'b0;
            if (!r) begin
                mq = 0; mc = 0;
            end else if (e) begin
                if (m == 2'b11) begin
                    mq = int'(dd); mc = 0;
                end else if (m != 2'b00) begin
                    if (m == 2'b01) mq = (mq * 2 + int'(sr)) % 256;
                    else            mq = mq / 2 + 128 * int'(sl);
                    mc = mc + 1;
                    if (mc == W) begin
                        mc = 0; mw = 1'b1;
                    end
                end
            end
            check_all(1000 + i, 8'(mq), mc, mw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
